// File: rtl/serial_alu.sv
// serial_alu: digit-serial ALU for the 16-bit serial CPU datapath.
// Operands are captured on an accepted start and consumed DIGIT bits per
// cycle, LSB first. Results shift in from the MSB side. After N = WIDTH/DIGIT
// RUN cycles, done pulses for one cycle and the result is held.
// Optional feature macro: SERIAL_ALU_FLAGS_EN adds the zero and carry flag ports.
module serial_alu #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             carry
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;
    localparam logic [2:0] OP_SLTU  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [WIDTH-1:0]    a_sh_r;
    logic [WIDTH-1:0]    b_sh_r;
    logic [2:0]          op_r;
    logic                carry_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [DIGIT-1:0]       a_d_s;
    logic [DIGIT-1:0]       b_d_s;
    logic [DIGIT:0]         sum_s;
    logic [DIGIT-1:0]       res_d_s;
    logic                   cout_s;
    logic [WIDTH+DIGIT-1:0] shift_s;
    logic [WIDTH-1:0]       result_nxt_s;

`ifdef SERIAL_ALU_FLAGS_EN
    assign carry = carry_r;
`endif

    // Current digit: arithmetic/logic slice, carry-out and next result value.
    always_comb begin
        a_d_s        = a_sh_r[DIGIT-1:0];
        b_d_s        = b_sh_r[DIGIT-1:0];
        sum_s        = '0;
        res_d_s      = '0;
        cout_s       = 1'b0;
        shift_s      = '0;
        result_nxt_s = '0;
        case (op_r)
            OP_ADD: begin
                sum_s   = {1'b0, a_d_s} + {1'b0, b_d_s} + {{DIGIT{1'b0}}, carry_r};
                res_d_s = sum_s[DIGIT-1:0];
                cout_s  = sum_s[DIGIT];
            end
            OP_SUB: begin
                sum_s   = {1'b0, a_d_s} + {1'b0, ~b_d_s} + {{DIGIT{1'b0}}, carry_r};
                res_d_s = sum_s[DIGIT-1:0];
                cout_s  = sum_s[DIGIT];
            end
            OP_SLTU: begin
                // Run the subtraction only for its borrow; digits shift in as zero.
                sum_s   = {1'b0, a_d_s} + {1'b0, ~b_d_s} + {{DIGIT{1'b0}}, carry_r};
                res_d_s = '0;
                cout_s  = sum_s[DIGIT];
            end
            OP_AND:   res_d_s = a_d_s & b_d_s;
            OP_OR:    res_d_s = a_d_s | b_d_s;
            OP_XOR:   res_d_s = a_d_s ^ b_d_s;
            OP_PASSB: res_d_s = b_d_s;
            default: begin
                res_d_s = '0;
                cout_s  = 1'b0;
            end
        endcase
        shift_s = {res_d_s, result};
        if ((op_r == OP_SLTU) && (cnt_r == LAST)) begin
            result_nxt_s = {{(WIDTH-1){1'b0}}, ~cout_s};
        end else begin
            result_nxt_s = shift_s[WIDTH+DIGIT-1:DIGIT];
        end
    end

    // Control FSM, operand shifters, carry chain and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            op_r    <= OP_ADD;
`ifdef SERIAL_ALU_FLAGS_EN
            zero    <= 1'b1;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        op_r    <= op;
                        cnt_r   <= '0;
                        // Subtraction-style ops start with carry-in 1 (two's complement).
                        carry_r <= ((op == OP_SUB) || (op == OP_SLTU)) ? 1'b1 : 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh_r  <= a_sh_r >> DIGIT;
                    b_sh_r  <= b_sh_r >> DIGIT;
                    carry_r <= cout_s;
                    result  <= result_nxt_s;
`ifdef SERIAL_ALU_FLAGS_EN
                    zero    <= (result_nxt_s == '0);
`endif
                    if (cnt_r == LAST) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
